// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the Wishbone round-robin arbiter.
// The optional watchdog is enabled with the macro WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Index width for n requesters, never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ...
// with wrap-around; returns one-hot grant, its index, and whether any request exists.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int j;
      j     = 0;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (!valid && req[j]) begin
            valid  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone B3 round-robin arbiter: registered grant held for the whole cyc, combinational
// datapath mux. Define WB_ARB_TIMEOUT_EN to add a stalled-slave watchdog.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_MASTERS-1:0]      m_cyc,
   input  logic [NUM_MASTERS-1:0]      m_stb,
   input  logic [NUM_MASTERS-1:0]      m_we,
   input  logic [NUM_MASTERS*AW-1:0]   m_adr,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
   input  logic [NUM_MASTERS*3-1:0]    m_cti,
   input  logic [NUM_MASTERS*2-1:0]    m_bte,
   output logic [NUM_MASTERS-1:0]      m_ack,
   output logic [NUM_MASTERS-1:0]      m_err,
   output logic [DW-1:0]               m_dat_o,
   output logic                        s_cyc,
   output logic                        s_stb,
   output logic                        s_we,
   output logic [AW-1:0]               s_adr,
   output logic [DW-1:0]               s_dat,
   output logic [DW/8-1:0]             s_sel,
   output logic [2:0]                  s_cti,
   output logic [1:0]                  s_bte,
   input  logic                        s_ack,
   input  logic                        s_err,
   input  logic [DW-1:0]               s_dat_i,
   output logic [NUM_MASTERS-1:0]      grant
);

   localparam int IW = clog2(NUM_MASTERS);
   localparam int SW = DW / 8;

   logic                   state_reg, state_next;
   logic [NUM_MASTERS-1:0] grant_reg, grant_next;
   logic [IW-1:0]          last_reg, last_next;
   logic [IW-1:0]          gidx_reg, gidx_next;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic                   pick_valid;
   logic                   busy, own_cyc, own_stb, kill;

   wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
      .req   (m_cyc),
      .last  (last_reg),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign busy    = (state_reg == ST_BUSY);
   assign own_cyc = m_cyc[gidx_reg];
   assign own_stb = m_stb[gidx_reg];
   assign grant   = grant_reg;
   assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = (clog2(TIMEOUT + 1) < 8) ? 8 : clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_reg, wd_next;

   // Counts stalled strobe cycles; any ack/err or a fresh grant restarts it.
   always_comb begin
      wd_next = wd_reg;
      if (!busy || s_ack || s_err) wd_next = '0;
      else if (own_stb)            wd_next = wd_reg + 1'b1;
   end

   assign kill = busy && own_stb && !s_ack && !s_err && (wd_reg == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) wd_reg <= '0;
      else       wd_reg <= wd_next;
   end
`else
   assign kill = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         grant_reg <= '0;
         last_reg  <= IW'(NUM_MASTERS - 1);
         gidx_reg  <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
         gidx_reg  <= gidx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      gidx_next  = gidx_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               state_next = ST_BUSY;
               grant_next = pick_gnt;
               gidx_next  = pick_idx;
            end
         end
         default: begin
            if (!own_cyc || kill) begin
               state_next = ST_IDLE;
               grant_next = '0;
               last_next  = gidx_reg;
            end
         end
      endcase
   end

   // Owner's bus passes straight through; a watchdog expiry masks cyc/stb for that cycle.
   always_comb begin
      s_cyc = 1'b0;
      s_stb = 1'b0;
      s_we  = 1'b0;
      s_adr = '0;
      s_dat = '0;
      s_sel = '0;
      s_cti = '0;
      s_bte = '0;
      m_ack = '0;
      m_err = '0;
      if (busy) begin
         s_cyc           = own_cyc & ~kill;
         s_stb           = own_stb & ~kill;
         s_we            = m_we[gidx_reg];
         s_adr           = m_adr[int'(gidx_reg)*AW +: AW];
         s_dat           = m_dat[int'(gidx_reg)*DW +: DW];
         s_sel           = m_sel[int'(gidx_reg)*SW +: SW];
         s_cti           = m_cti[int'(gidx_reg)*3 +: 3];
         s_bte           = m_bte[int'(gidx_reg)*2 +: 2];
         m_ack[gidx_reg] = s_ack;
         m_err[gidx_reg] = s_err | kill;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with a small latency-configurable slave model.
// The watchdog scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;
   import wb_arb_pkg::*;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NM-1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
   logic [NM*AW-1:0]    m_adr = '0;
   logic [NM*DW-1:0]    m_dat = '0;
   logic [NM*SW-1:0]    m_sel = '0;
   logic [NM*3-1:0]     m_cti = '0;
   logic [NM*2-1:0]     m_bte = '0;
   logic [NM-1:0]       m_ack, m_err, grant;
   logic [DW-1:0]       m_dat_o;
   logic                s_cyc, s_stb, s_we;
   logic [AW-1:0]       s_adr;
   logic [DW-1:0]       s_dat;
   logic [SW-1:0]       s_sel;
   logic [2:0]          s_cti;
   logic [1:0]          s_bte;
   logic                s_ack = 1'b0;
   logic                s_err = 1'b0;
   logic [DW-1:0]       s_dat_i;

   int errors = 0;
   int checks = 0;
   int slv_lat = 2;
   bit slv_en = 1'b1;
   int wcnt = 0;
   logic [DW-1:0] wr_last = '0;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat(m_dat),
      .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(m_ack), .m_err(m_err),
      .m_dat_o(m_dat_o), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat(s_dat), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack),
      .s_err(s_err), .s_dat_i(s_dat_i), .grant(grant)
   );

   // Slave model: read data derived from address, ack after slv_lat strobe cycles.
   assign s_dat_i = s_adr ^ 32'hDEAD0000;

   always @(posedge clk) begin
      if (reset) begin
         s_ack <= 1'b0;
         wcnt  <= 0;
      end else if (slv_en && s_cyc && s_stb && !s_ack) begin
         if (wcnt == slv_lat - 1) begin
            s_ack <= 1'b1;
            wcnt  <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         s_ack <= 1'b0;
         wcnt  <= 0;
      end
      if (s_ack && s_stb && s_we) wr_last <= s_dat;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input bit cyc, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      m_cyc[m]          = cyc;
      m_stb[m]          = cyc;
      m_we[m]           = we;
      m_adr[m*AW +: AW] = adr;
      m_dat[m*DW +: DW] = dat;
      m_sel[m*SW +: SW] = '1;
      m_cti[m*3 +: 3]   = cti;
      m_bte[m*2 +: 2]   = 2'b00;
   endtask

   task automatic wait_ack(input int m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_ack[m]) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
      checks++; if (s_adr !== 32'h0) begin errors++; $display("FAIL reset_s_adr got=%h exp=0", s_adr); end
      checks++; if ({m_ack, m_err} !== 8'h00) begin errors++; $display("FAIL reset_ack_err got=%b exp=0", {m_ack, m_err}); end
      $display("test_reset done: grant=%b s_cyc=%b", grant, s_cyc);
   endtask

   task automatic test_single();
      bit ok;
      set_m(0, 1, 1, 32'h1000, 32'h12345678, CTI_CLASSIC);
      #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_req_cycle_s_cyc got=%b exp=0", s_cyc); end
      tick();
      checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL single_s_cyc got=%b exp=1", s_cyc); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", grant); end
      checks++; if (s_adr !== 32'h1000) begin errors++; $display("FAIL single_wr_adr got=%h exp=00001000", s_adr); end
      checks++; if (s_dat !== 32'h12345678) begin errors++; $display("FAIL single_wr_dat got=%h exp=12345678", s_dat); end
      wait_ack(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_wr_ack got=timeout exp=ack"); end
      checks++; if (m_ack[3:1] !== 3'b000) begin errors++; $display("FAIL single_other_ack got=%b exp=000", m_ack[3:1]); end
      tick();
      set_m(0, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_s_cyc_drop got=%b exp=0", s_cyc); end
      checks++; if (wr_last !== 32'h12345678) begin errors++; $display("FAIL single_slave_wdata got=%h exp=12345678", wr_last); end
      tick();
      set_m(0, 1, 0, 32'h1004, 32'h0, CTI_CLASSIC);
      tick();
      wait_ack(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_rd_ack got=timeout exp=ack"); end
      checks++; if (m_dat_o !== 32'hDEAD1004) begin errors++; $display("FAIL single_rd_data got=%h exp=dead1004", m_dat_o); end
      tick();
      set_m(0, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      $display("test_single done: wr=%h rd=%h", wr_last, m_dat_o);
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      set_m(0, 1, 1, 32'h0100, 32'hA0, CTI_CLASSIC);
      set_m(2, 1, 1, 32'h0200, 32'hA2, CTI_CLASSIC);
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL simul_first got=%b exp=0001", grant); end
      wait_ack(0, ok);
      tick();
      set_m(0, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      checks++; if (grant !== 4'b0000 || s_cyc !== 1'b0) begin errors++; $display("FAIL simul_idle_gap got grant=%b s_cyc=%b exp 0000/0", grant, s_cyc); end
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL simul_second got=%b exp=0100", grant); end
      wait_ack(2, ok);
      tick();
      set_m(2, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      set_m(0, 1, 1, 32'h0100, 32'hA0, CTI_CLASSIC);
      set_m(2, 1, 1, 32'h0200, 32'hA2, CTI_CLASSIC);
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL simul_wrap got=%b exp=0001", grant); end
      wait_ack(0, ok);
      tick();
      set_m(0, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      set_m(2, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      $display("test_simultaneous done");
   endtask

   task automatic test_burst();
      bit ok;
      // last=0 here, so master 1 is ahead of master 3.
      set_m(1, 1, 0, 32'h2000, 32'h0, CTI_INCR);
      set_m(3, 1, 1, 32'h3000, 32'h33, CTI_CLASSIC);
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL burst_grant got=%b exp=0010", grant); end
      for (int b = 0; b < 4; b++) begin
         wait_ack(1, ok);
         checks++; if (!ok || grant !== 4'b0010 || m_ack[3] !== 1'b0) begin
            errors++; $display("FAIL burst_beat%0d got ok=%b grant=%b ack3=%b exp 1/0010/0", b, ok, grant, m_ack[3]);
         end
         checks++; if (s_adr !== 32'h2000 + 32'(b*4)) begin errors++; $display("FAIL burst_adr%0d got=%h exp=%h", b, s_adr, 32'h2000 + 32'(b*4)); end
         tick();
         if (b < 3) set_m(1, 1, 0, 32'h2000 + 32'((b+1)*4), 32'h0, (b == 2) ? CTI_EOB : CTI_INCR);
      end
      set_m(1, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      #1;
      checks++; if (s_cyc !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL burst_end got s_cyc=%b grant=%b exp 0/0010", s_cyc, grant); end
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL burst_idle got=%b exp=0000", grant); end
      tick();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL burst_next_owner got=%b exp=1000", grant); end
      wait_ack(3, ok);
      tick();
      set_m(3, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      $display("test_burst done");
   endtask

   task automatic test_reset_mid();
      set_m(1, 1, 0, 32'h4000, 32'h0, CTI_INCR);
      tick();
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_grant got=%b exp=0010", grant); end
      reset = 1'b1;
      tick();
      checks++; if (s_cyc !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL rstmid_clear got s_cyc=%b grant=%b exp 0/0000", s_cyc, grant); end
      set_m(1, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      reset = 1'b0;
      set_m(2, 1, 1, 32'h5000, 32'h55, CTI_CLASSIC);
      set_m(3, 1, 1, 32'h6000, 32'h66, CTI_CLASSIC);
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rstmid_after got=%b exp=0100", grant); end
      set_m(2, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      set_m(3, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      tick();
      $display("test_reset_mid done");
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      slv_en = 1'b0;
      set_m(0, 1, 1, 32'h7000, 32'h77, CTI_CLASSIC);
      set_m(1, 1, 1, 32'h7100, 32'h71, CTI_CLASSIC);
      tick();
      for (int c = 1; c < 16; c++) begin
         checks++; if (m_err[0] !== 1'b0) begin errors++; $display("FAIL timeout_early_c%0d got=%b exp=0", c, m_err[0]); end
         tick();
      end
      checks++; if (m_err[0] !== 1'b1 || s_cyc !== 1'b0) begin errors++; $display("FAIL timeout_pulse got err=%b s_cyc=%b exp 1/0", m_err[0], s_cyc); end
      set_m(0, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL timeout_next got=%b exp=0010", grant); end
      set_m(1, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      slv_en = 1'b1;
      tick();
      $display("test_timeout done");
   endtask
`endif

   task automatic test_fairness();
      bit ok;
      logic [NM-1:0] one;
      int exp;
      one = 1;
      exp = 0;
      do_reset();
      for (int m = 0; m < NM; m++) set_m(m, 1, 1, 32'h8000 + 32'(m), 32'(m), CTI_CLASSIC);
      for (int n = 0; n < 8; n++) begin
         ok = 1'b0;
         for (int t = 0; t < 10; t++) begin
            if (grant != '0) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         checks++; if (!ok || grant !== (one << exp)) begin errors++; $display("FAIL fair_turn%0d got=%b exp=%b", n, grant, one << exp); end
         $display("fair turn %0d: grant=%b", n, grant);
         wait_ack(exp, ok);
         tick();
         set_m(exp, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
         tick();
         set_m(exp, 1, 1, 32'h8000 + 32'(exp), 32'(exp), CTI_CLASSIC);
         exp = (exp + 1) % NM;
      end
      for (int m = 0; m < NM; m++) set_m(m, 0, 0, 32'h0, 32'h0, CTI_CLASSIC);
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_burst();
      test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_fairness();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone B3 slave port among NUM_MASTERS bus masters, e.g. several wb test masters or cores driving one memory controller port.
- Round-robin grant, held for the whole cycle (cyc high), so classic and burst (cti/bte) cycles pass through unbroken.
- Grant is registered; the datapath is a combinational mux selected by the registered grant.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width. Sel width is DW/8.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- m_cyc  in  NUM_MASTERS  per-master cyc.
- m_stb  in  NUM_MASTERS  per-master stb.
- m_we  in  NUM_MASTERS  per-master we.
- m_adr  in  NUM_MASTERS*AW  flattened addresses; master i uses [i*AW +: AW].
- m_dat  in  NUM_MASTERS*DW  flattened write data.
- m_sel  in  NUM_MASTERS*DW/8  flattened byte selects.
- m_cti  in  NUM_MASTERS*3  flattened cycle type.
- m_bte  in  NUM_MASTERS*2  flattened burst type.
- m_ack  out  NUM_MASTERS  per-master ack.
- m_err  out  NUM_MASTERS  per-master err.
- m_dat_o  out  DW  read data, broadcast to all masters.
- s_cyc, s_stb, s_we  out  1 each  slave control.
- s_adr  out  AW  slave address.
- s_dat  out  DW  slave write data.
- s_sel  out  DW/8  slave byte selects.
- s_cti  out  3  slave cycle type.
- s_bte  out  2  slave burst type.
- s_ack  in  1  slave ack.
- s_err  in  1  slave err.
- s_dat_i  in  DW  slave read data.
- grant  out  NUM_MASTERS  one-hot current owner; debug/bench visibility.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State machine: IDLE and BUSY.
  - Registers: state; grant (one-hot); last (index of the previous owner).
  - Reset: state=IDLE, grant=0, last=NUM_MASTERS-1, so master 0 wins first.
- IDLE:
  - Slave outputs driven: s_cyc=0, s_stb=0, s_we=0, s_adr=0, s_dat=0, s_sel=0, s_cti=0, s_bte=0.
  - All m_ack=0, m_err=0.
  - If any m_cyc is high, pick the first requester scanning last+1, last+2, ... with wrap-around. Next cycle: state=BUSY, grant=that one-hot.
- BUSY, with granted index g:
  - All s_* outputs = master g's signals, combinationally.
  - m_ack[g]=s_ack and m_err[g]=s_err; every other m_ack/m_err=0.
  - m_dat_o=s_dat_i at all times.
  - When m_cyc[g]=0 (sampled): next cycle state=IDLE, grant=0, last=g.
  - s_cyc therefore drops in the same cycle the master drops cyc.
- Latency:
  - A request in cycle N is granted, with s_cyc high, in cycle N+1.
  - Back-to-back owners have exactly one idle cycle between them (the IDLE re-arbitration cycle).
- Bursts: the grant is never revoked while m_cyc[g]=1, regardless of cti/bte or other requests.
- Simultaneous requests: strict round-robin from last+1. For example, with last=1 and requests 0b1011, master 3 wins.
- A request withdrawn during IDLE before grant: the arbiter re-evaluates each cycle; no phantom grant occurs.
- Reset mid-cycle: immediate return to reset values on the next edge; the slave sees s_cyc=0.
- Non-granted masters wait with cyc/stb high and receive no ack.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on grant and on every s_ack or s_err.
  - It increments each BUSY cycle where s_stb=1 and there is no ack.
  - On reaching TIMEOUT: m_err[g] is pulsed for 1 cycle, s_cyc/s_stb are forced to 0 that cycle, and the next state is IDLE with last=g.
  - The master must then drop cyc.
- Undefined: no counter; m_err passes s_err only.

Decomposition:
- Package wb_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - Wishbone cti constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - a clog2 function for index width.
- One sub-module, wb_rr_pick: a combinational round-robin priority picker. Inputs req and last; outputs one-hot gnt, index, and valid.

Test Plan:
- Single master 0: write 0x12345678 to 0x1000, then read 0x1004 with slave model ack latency 2.
  - s_adr/s_dat match; s_cyc rises one cycle after m_cyc[0].
  - m_dat_o returns the model data; m_ack[1..3]=0.
- Masters 0 and 2 request in the same cycle after reset.
  - Grant 0b0001 first, then 0b0100 after one IDLE cycle.
  - A repeat request from both gives 0 again (last=2 wraps to 3, then 0).
- Master 1 runs a 4-beat incrementing burst (cti=010, last beat 111) while master 3 requests.
  - grant stays 0b0010 for all 4 acks; master 3 is granted only after m_cyc[1] falls.
- Reset asserted while BUSY mid-burst.
  - Next edge: s_cyc=0, grant=0, state=IDLE.
  - The following request from master 2 wins (last reset to 3).
- With WB_ARB_TIMEOUT_EN and TIMEOUT=16, the slave never acks.
  - m_err[0] pulses in exactly cycle 16 of the stall; s_cyc=0 that cycle.
  - Master 1's pending request is granted afterwards.
- Continuous requests from all 4 masters, each doing one single-beat cycle.
  - Grant order 0,1,2,3,0,...; no master is starved over 20 cycles.
